// File: rtl/bayer_window_5x5.sv
// Raster Bayer stream to 13-tap diamond window (5x5) with colour code, zero-filled borders
// and a self-timed flush of the last two rows plus two pixels after each frame.
module bayer_window_5x5 #(
  parameter int unsigned IMG_WIDTH     = 640,
  parameter int unsigned IMG_HEIGHT    = 480,
  parameter int unsigned BAYER_PATTERN = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_sof,
  input  logic [7:0] in_data,
  output logic [7:0] matrix_p13,
  output logic [7:0] matrix_p22,
  output logic [7:0] matrix_p23,
  output logic [7:0] matrix_p24,
  output logic [7:0] matrix_p31,
  output logic [7:0] matrix_p32,
  output logic [7:0] matrix_p33,
  output logic [7:0] matrix_p34,
  output logic [7:0] matrix_p35,
  output logic [7:0] matrix_p42,
  output logic [7:0] matrix_p43,
  output logic [7:0] matrix_p44,
  output logic [7:0] matrix_p53,
  output logic [3:0] bayer_state,
  output logic       clken,
  output logic       out_sof,
  output logic       out_eof
);

  localparam int unsigned CW  = $clog2(IMG_WIDTH);
  localparam int unsigned RW  = $clog2(IMG_HEIGHT + 3);
  localparam int unsigned OW  = $clog2(IMG_HEIGHT + 1);
  localparam logic [1:0]  PAT = 2'(BAYER_PATTERN);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t        r_state;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_ocol;
  logic [OW-1:0] r_orow;

  logic [7:0] r_lb0 [0:IMG_WIDTH-1];
  logic [7:0] r_lb1 [0:IMG_WIDTH-1];
  logic [7:0] r_lb2 [0:IMG_WIDTH-1];
  logic [7:0] r_lb3 [0:IMG_WIDTH-1];

  // Per-row column history; index 0 is the column just left of the newest one.
  logic [7:0] r_sh1 [0:1];
  logic [7:0] r_sh2 [0:2];
  logic [7:0] r_sh3 [0:3];
  logic [7:0] r_sh4 [0:2];
  logic [7:0] r_sh5 [0:1];

  logic          w_start, w_adv, w_emit, w_primed, w_last_in, w_last_out;
  logic [CW-1:0] w_addr;
  logic [7:0]    w_din, w_v1, w_v2, w_v3, w_v4;
  logic          w_rok_m2, w_rok_m1, w_rok_p1, w_rok_p2;
  logic          w_cok_m2, w_cok_m1, w_cok_p1, w_cok_p2;
  logic          w_pr, w_pc;
  logic [3:0]    w_bayer;

  assign w_start    = in_valid & in_sof;
  assign w_adv      = w_start | ((r_state == S_RUN) & in_valid) | (r_state == S_FLUSH);
  assign w_din      = ((r_state == S_FLUSH) && !w_start) ? '0 : in_data;
  assign w_addr     = w_start ? '0 : r_col;
  assign w_primed   = (r_row > RW'(2)) || ((r_row == RW'(2)) && (r_col >= CW'(2)));
  assign w_emit     = w_adv & ~w_start & ((r_state == S_FLUSH) | w_primed);
  assign w_last_in  = (r_state == S_RUN) & in_valid & ~in_sof &
                      (r_row == RW'(IMG_HEIGHT - 1)) & (r_col == CW'(IMG_WIDTH - 1));
  assign w_last_out = (r_orow == OW'(IMG_HEIGHT - 1)) && (r_ocol == CW'(IMG_WIDTH - 1));

  assign w_v1 = r_lb0[w_addr];
  assign w_v2 = r_lb1[w_addr];
  assign w_v3 = r_lb2[w_addr];
  assign w_v4 = r_lb3[w_addr];

  assign w_rok_m2 = r_orow >= OW'(2);
  assign w_rok_m1 = r_orow != '0;
  assign w_rok_p1 = r_orow < OW'(IMG_HEIGHT - 1);
  assign w_rok_p2 = r_orow < OW'(IMG_HEIGHT - 2);
  assign w_cok_m2 = r_ocol >= CW'(2);
  assign w_cok_m1 = r_ocol != '0;
  assign w_cok_p1 = r_ocol < CW'(IMG_WIDTH - 1);
  assign w_cok_p2 = r_ocol < CW'(IMG_WIDTH - 2);

  // Every pattern is RGGB with its row and/or column phase flipped.
  assign w_pr = r_orow[0] ^ PAT[1];
  assign w_pc = r_ocol[0] ^ PAT[0];

  always_comb begin
    w_bayer = 4'b0100;
    case ({w_pr, w_pc})
      2'b00: w_bayer = 4'b0100;
      2'b01: w_bayer = 4'b1000;
      2'b10: w_bayer = 4'b0001;
      2'b11: w_bayer = 4'b0010;
    endcase
  end

  // Line buffer contents deliberately survive reset; border masking hides stale data.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_lb0[w_addr] <= w_din;
      r_lb1[w_addr] <= w_v1;
      r_lb2[w_addr] <= w_v2;
      r_lb3[w_addr] <= w_v3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_ocol      <= '0;
      r_orow      <= '0;
      r_sh1       <= '{default: '0};
      r_sh2       <= '{default: '0};
      r_sh3       <= '{default: '0};
      r_sh4       <= '{default: '0};
      r_sh5       <= '{default: '0};
      matrix_p13  <= '0;
      matrix_p22  <= '0;
      matrix_p23  <= '0;
      matrix_p24  <= '0;
      matrix_p31  <= '0;
      matrix_p32  <= '0;
      matrix_p33  <= '0;
      matrix_p34  <= '0;
      matrix_p35  <= '0;
      matrix_p42  <= '0;
      matrix_p43  <= '0;
      matrix_p44  <= '0;
      matrix_p53  <= '0;
      bayer_state <= '0;
      clken       <= 1'b0;
      out_sof     <= 1'b0;
      out_eof     <= 1'b0;
    end else begin
      clken   <= 1'b0;
      out_sof <= 1'b0;
      out_eof <= 1'b0;

      if (w_adv) begin
        r_sh1[0] <= w_v4;  r_sh1[1] <= r_sh1[0];
        r_sh2[0] <= w_v3;  r_sh2[1] <= r_sh2[0];  r_sh2[2] <= r_sh2[1];
        r_sh3[0] <= w_v2;  r_sh3[1] <= r_sh3[0];  r_sh3[2] <= r_sh3[1];  r_sh3[3] <= r_sh3[2];
        r_sh4[0] <= w_v1;  r_sh4[1] <= r_sh4[0];  r_sh4[2] <= r_sh4[1];
        r_sh5[0] <= w_din; r_sh5[1] <= r_sh5[0];
      end

      if (w_start) begin
        r_col   <= CW'(1);
        r_row   <= '0;
        r_ocol  <= '0;
        r_orow  <= '0;
        r_state <= S_RUN;
      end else if (w_adv) begin
        if (r_col == CW'(IMG_WIDTH - 1)) begin
          r_col <= '0;
          r_row <= r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
        if (w_last_in) r_state <= S_FLUSH;
      end

      if (w_emit) begin
        matrix_p13  <= w_rok_m2              ? r_sh1[1] : '0;
        matrix_p22  <= (w_rok_m1 & w_cok_m1) ? r_sh2[2] : '0;
        matrix_p23  <= w_rok_m1              ? r_sh2[1] : '0;
        matrix_p24  <= (w_rok_m1 & w_cok_p1) ? r_sh2[0] : '0;
        matrix_p31  <= w_cok_m2              ? r_sh3[3] : '0;
        matrix_p32  <= w_cok_m1              ? r_sh3[2] : '0;
        matrix_p33  <= r_sh3[1];
        matrix_p34  <= w_cok_p1              ? r_sh3[0] : '0;
        matrix_p35  <= w_cok_p2              ? w_v2     : '0;
        matrix_p42  <= (w_rok_p1 & w_cok_m1) ? r_sh4[2] : '0;
        matrix_p43  <= w_rok_p1              ? r_sh4[1] : '0;
        matrix_p44  <= (w_rok_p1 & w_cok_p1) ? r_sh4[0] : '0;
        matrix_p53  <= w_rok_p2              ? r_sh5[1] : '0;
        bayer_state <= w_bayer;
        clken       <= 1'b1;
        out_sof     <= (r_orow == '0) && (r_ocol == '0);
        out_eof     <= w_last_out;
        if (w_last_out) begin
          r_ocol <= '0;
          r_orow <= '0;
          if (r_state == S_FLUSH) r_state <= S_IDLE;
        end else if (r_ocol == CW'(IMG_WIDTH - 1)) begin
          r_ocol <= '0;
          r_orow <= r_orow + OW'(1);
        end else begin
          r_ocol <= r_ocol + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_bayer_window_5x5.sv
// Scoreboard bench for bayer_window_5x5 (8x6 frames, RGGB and BGGR instances side by side).
module tb_bayer_window_5x5;

  localparam int W   = 8;
  localparam int H   = 6;
  localparam int N   = W * H;
  localparam int PRE = 2 * W + 2;

  localparam logic [3:0] C_R  = 4'b0100;
  localparam logic [3:0] C_GR = 4'b1000;
  localparam logic [3:0] C_GB = 4'b0001;
  localparam logic [3:0] C_B  = 4'b0010;

  localparam logic [103:0] HK0  = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2,
                                   8'd0, 8'd8, 8'd9, 8'd16};
  localparam logic [103:0] HK27 = {8'd11, 8'd18, 8'd19, 8'd20, 8'd25, 8'd26, 8'd27, 8'd28,
                                   8'd29, 8'd34, 8'd35, 8'd36, 8'd43};
  localparam logic [103:0] HK47 = {8'd31, 8'd38, 8'd39, 8'd0, 8'd45, 8'd46, 8'd47, 8'd0,
                                   8'd0, 8'd0, 8'd0, 8'd0, 8'd0};

  logic       clk;
  logic       rst, in_valid, in_sof;
  logic [7:0] in_data;

  logic [7:0] a13, a22, a23, a24, a31, a32, a33, a34, a35, a42, a43, a44, a53;
  logic [7:0] b13, b22, b23, b24, b31, b32, b33, b34, b35, b42, b43, b44, b53;
  logic [3:0] bs0, bs3;
  logic       clken0, clken3, sof0, sof3, eof0, eof3;
  logic [103:0] a_taps, b_taps;

  assign a_taps = {a13, a22, a23, a24, a31, a32, a33, a34, a35, a42, a43, a44, a53};
  assign b_taps = {b13, b22, b23, b24, b31, b32, b33, b34, b35, b42, b43, b44, b53};

  bayer_window_5x5 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .BAYER_PATTERN(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .matrix_p13(a13), .matrix_p22(a22), .matrix_p23(a23), .matrix_p24(a24),
    .matrix_p31(a31), .matrix_p32(a32), .matrix_p33(a33), .matrix_p34(a34), .matrix_p35(a35),
    .matrix_p42(a42), .matrix_p43(a43), .matrix_p44(a44), .matrix_p53(a53),
    .bayer_state(bs0), .clken(clken0), .out_sof(sof0), .out_eof(eof0)
  );

  bayer_window_5x5 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .BAYER_PATTERN(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
    .matrix_p13(b13), .matrix_p22(b22), .matrix_p23(b23), .matrix_p24(b24),
    .matrix_p31(b31), .matrix_p32(b32), .matrix_p33(b33), .matrix_p34(b34), .matrix_p35(b35),
    .matrix_p42(b42), .matrix_p43(b43), .matrix_p44(b44), .matrix_p53(b53),
    .bayer_state(bs3), .clken(clken3), .out_sof(sof3), .out_eof(eof3)
  );

  typedef struct {
    int           cyc;
    int           k;
    logic [103:0] taps;
    logic [3:0]   bs0;
    logic [3:0]   bs3;
    logic         sof;
    logic         eof;
  } exp_t;

  exp_t         q[$];
  logic [7:0]   fr [0:N-1];
  logic [103:0] cap_taps [0:N-1];
  logic [3:0]   cap_bs0 [0:N-1];
  logic [3:0]   cap_bs3 [0:N-1];
  logic         cap_eof [0:N-1];
  int           cyc = 0;
  int           n_assert = 0;
  int           n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [103:0] act, input logic [103:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] px(input int k, input int dr, input int dc);
    int rr, cc;
    rr = k / W + dr;
    cc = k % W + dc;
    if (rr < 0 || rr >= H || cc < 0 || cc >= W) return 8'h00;
    return fr[rr * W + cc];
  endfunction

  function automatic logic [3:0] colour(input int pat, input int k);
    logic [3:0] t [4];
    case (pat)
      0:       t = '{C_R,  C_GR, C_GB, C_B};
      1:       t = '{C_GR, C_R,  C_B,  C_GB};
      2:       t = '{C_GB, C_B,  C_R,  C_GR};
      default: t = '{C_B,  C_GB, C_GR, C_R};
    endcase
    return t[((k / W) % 2) * 2 + (k % W) % 2];
  endfunction

  task automatic push_exp(input int k, input int at);
    exp_t e;
    e.cyc  = at;
    e.k    = k;
    e.taps = {px(k, -2, 0), px(k, -1, -1), px(k, -1, 0), px(k, -1, 1),
              px(k, 0, -2), px(k, 0, -1), px(k, 0, 0), px(k, 0, 1), px(k, 0, 2),
              px(k, 1, -1), px(k, 1, 0), px(k, 1, 1), px(k, 2, 0)};
    e.bs0  = colour(0, k);
    e.bs3  = colour(3, k);
    e.sof  = (k == 0);
    e.eof  = (k == N - 1);
    q.push_back(e);
  endtask

  // Monitor: an output is expected exactly on the cycle stamped in the queue head.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        chk("clken", 104'(clken0), 104'd1);
        chk("clken3", 104'(clken3), 104'd1);
        if (clken0) begin
          chk($sformatf("taps k=%0d", e.k), a_taps, e.taps);
          chk($sformatf("taps3 k=%0d", e.k), b_taps, e.taps);
          chk($sformatf("bayer k=%0d", e.k), 104'(bs0), 104'(e.bs0));
          chk($sformatf("bayer3 k=%0d", e.k), 104'(bs3), 104'(e.bs3));
          chk($sformatf("sof k=%0d", e.k), 104'(sof0), 104'(e.sof));
          chk($sformatf("eof k=%0d", e.k), 104'(eof0), 104'(e.eof));
          cap_taps[e.k] = a_taps;
          cap_bs0[e.k]  = bs0;
          cap_bs3[e.k]  = bs3;
          cap_eof[e.k]  = eof0;
        end
      end else begin
        chk("clken_idle", 104'(clken0), 104'd0);
        chk("clken3_idle", 104'(clken3), 104'd0);
      end
    end
  end

  task automatic clear_cap();
    for (int k = 0; k < N; k++) begin
      cap_taps[k] = '1;
      cap_bs0[k]  = '1;
      cap_bs3[k]  = '1;
      cap_eof[k]  = 1'b0;
    end
  endtask

  task automatic idle(input int m);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    repeat (m) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int gap, input int variant, input int cnt);
    for (int n = 0; n < cnt; n++) begin
      if (gap != 0 && n > 0) idle(1);
      fr[n]    = (variant == 0) ? 8'(n) : 8'((n * 37 + variant * 11) % 256);
      in_valid = 1'b1;
      in_sof   = (n == 0);
      in_data  = fr[n];
      if (n >= PRE) push_exp(n - PRE, cyc + 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic flush_idle(input int m, input logic junk);
    int last;
    last = cyc;
    for (int i = 0; i < m; i++) begin
      if (i < PRE) push_exp(N - PRE + i, last + 1 + i);
      in_valid = junk;
      in_sof   = 1'b0;
      in_data  = 8'hAA;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " taps"}, a_taps, '0);
    chk({nm, " taps3"}, b_taps, '0);
    chk({nm, " bayer"}, 104'(bs0), '0);
    chk({nm, " bayer3"}, 104'(bs3), '0);
    chk({nm, " clken"}, 104'(clken0), '0);
    chk({nm, " sof"}, 104'(sof0), '0);
    chk({nm, " eof"}, 104'(eof0), '0);
    chk({nm, " sof3/eof3"}, 104'({sof3, eof3}), '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, cycle=%0d", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    idle(2);

    // Continuous ramp frame with full flush.
    clear_cap();
    send_frame(0, 0, N);
    flush_idle(PRE + 4, 1'b0);
    chk("direct k0 taps", cap_taps[0], HK0);
    chk("direct k27 taps", cap_taps[27], HK27);
    chk("direct k47 taps", cap_taps[47], HK47);
    chk("direct k47 eof", 104'(cap_eof[47]), 104'd1);
    chk("direct k0 bayer", 104'(cap_bs0[0]), 104'(4'b0100));
    chk("direct k27 bayer", 104'(cap_bs0[27]), 104'(4'b0010));
    chk("direct bggr k0", 104'(cap_bs3[0]), 104'(4'b0010));
    chk("direct bggr k1", 104'(cap_bs3[1]), 104'(4'b0001));
    chk("direct bggr k8", 104'(cap_bs3[8]), 104'(4'b1000));
    chk("direct bggr k9", 104'(cap_bs3[9]), 104'(4'b0100));

    // Valid without sof while idle must be ignored.
    repeat (4) begin
      in_valid = 1'b1; in_sof = 1'b0; in_data = 8'h55;
      @(posedge clk);
      #1;
    end
    idle(2);

    // Toggling in_valid; junk valid (no sof) during flush must be dropped.
    clear_cap();
    send_frame(1, 0, N);
    flush_idle(PRE + 4, 1'b1);
    chk("gapped k0 taps", cap_taps[0], HK0);
    chk("gapped k27 taps", cap_taps[27], HK27);
    chk("gapped k47 taps", cap_taps[47], HK47);
    idle(2);

    // Reset mid-RUN, then a fresh frame.
    send_frame(0, 1, 30);
    rst = 1'b1;
    q.delete();
    #1;
    chk_all_zero("midrst");
    @(posedge clk);
    #1;
    chk_all_zero("midrst held");
    rst = 1'b0;
    idle(1);
    clear_cap();
    send_frame(0, 0, N);
    flush_idle(PRE + 4, 1'b0);
    chk("after reset k0 taps", cap_taps[0], HK0);
    idle(2);

    // sof in the first flush cycle, then sof three cycles into a flush.
    send_frame(0, 2, N);
    flush_idle(0, 1'b0);
    send_frame(0, 3, N);
    flush_idle(3, 1'b0);
    clear_cap();
    send_frame(0, 0, N);
    flush_idle(PRE + 4, 1'b0);
    chk("last frame k27 taps", cap_taps[27], HK27);
    chk("last frame k47 taps", cap_taps[47], HK47);
    chk("last frame k47 eof", 104'(cap_eof[47]), 104'd1);
    idle(3);

    chk("queue drained", 104'(q.size()), 104'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
